// File: rtl/ps2_defs.sv
// Shared PS/2 definitions: scan-code constants, frame FSM state encoding and
// a set-2 hex digit lookup.
package ps2_defs;

  localparam logic [7:0] SC_BRK  = 8'hF0;
  localparam logic [7:0] SC_EXT  = 8'hE0;
  localparam logic [7:0] SC_BKSP = 8'h66;
  localparam logic [7:0] SC_ESC  = 8'h76;

  localparam logic [7:0] SC_D0 = 8'h45;
  localparam logic [7:0] SC_D1 = 8'h16;
  localparam logic [7:0] SC_D2 = 8'h1E;
  localparam logic [7:0] SC_D3 = 8'h26;
  localparam logic [7:0] SC_D4 = 8'h25;
  localparam logic [7:0] SC_D5 = 8'h2E;
  localparam logic [7:0] SC_D6 = 8'h36;
  localparam logic [7:0] SC_D7 = 8'h3D;
  localparam logic [7:0] SC_D8 = 8'h3E;
  localparam logic [7:0] SC_D9 = 8'h46;
  localparam logic [7:0] SC_DA = 8'h1C;
  localparam logic [7:0] SC_DB = 8'h32;
  localparam logic [7:0] SC_DC = 8'h21;
  localparam logic [7:0] SC_DD = 8'h23;
  localparam logic [7:0] SC_DE = 8'h24;
  localparam logic [7:0] SC_DF = 8'h2B;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} frame_state_e;

  // Returns {hit, digit}; hit = 0 for codes that are not hex keys.
  function automatic logic [4:0] hex_digit(input logic [7:0] sc);
    case (sc)
      SC_D0:   return 5'h10;
      SC_D1:   return 5'h11;
      SC_D2:   return 5'h12;
      SC_D3:   return 5'h13;
      SC_D4:   return 5'h14;
      SC_D5:   return 5'h15;
      SC_D6:   return 5'h16;
      SC_D7:   return 5'h17;
      SC_D8:   return 5'h18;
      SC_D9:   return 5'h19;
      SC_DA:   return 5'h1A;
      SC_DB:   return 5'h1B;
      SC_DC:   return 5'h1C;
      SC_DD:   return 5'h1D;
      SC_DE:   return 5'h1E;
      SC_DF:   return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input synchronisers, falling-edge detect, 11-bit frame
// FSM with odd-parity check and an inactivity timeout for partial frames.
module ps2_frame_rx
  import ps2_defs::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_prev_q;
  logic                   clk_s, data_s, fall;

  frame_state_e  state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          parity_q;
  logic [CntW-1:0] tmo_q;
  logic [7:0]    code_q;
  logic          code_valid_q, frame_err_q;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = clk_prev_q & ~clk_s;

  // Lines idle high, so synchronisers reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q  <= clk_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      tmo_q        <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (fall || state_q == StIdle) tmo_q <= '0;
      else                           tmo_q <= tmo_q + 1'b1;
      if (fall) begin
        unique case (state_q)
          StIdle: begin
            if (!data_s) begin
              state_q   <= StData;
              bit_cnt_q <= '0;
            end
          end
          StData: begin
            shift_q   <= {data_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_q <= StParity;
          end
          StParity: begin
            parity_q <= data_s;
            state_q  <= StStop;
          end
          StStop: begin
            if (data_s && (^shift_q ^ parity_q)) begin
              code_q       <= shift_q;
              code_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end else if (state_q != StIdle && tmo_q == TmoLast) begin
        state_q     <= StIdle;
        frame_err_q <= 1'b1;
      end
    end
  end

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_hex_entry.sv
// PS/2 hex keypad entry: decodes scan codes into an 8-digit hex value, a
// sticky error flag and a leading-digit blanking mask for the display.
module ps2_hex_entry
  import ps2_defs::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [31:0] NUMB,
  output logic        ERROR,
  output logic [7:0]  MASK,
  output logic [7:0]  code,
  output logic        code_valid
);

  logic        rx_err;
  logic [31:0] numb_q, numb_d;
  logic [3:0]  n_q, n_d, n_eff;
  logic        err_q, err_d, ext_q, ext_d, brk_q, brk_d;
  logic [4:0]  hex;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .code      (code),
    .code_valid(code_valid),
    .frame_err (rx_err)
  );

  always_comb begin
    numb_d = numb_q;
    n_d    = n_q;
    err_d  = err_q;
    ext_d  = ext_q;
    brk_d  = brk_q;
    hex    = hex_digit(code);
    if (code_valid) begin
      if (code == SC_EXT) begin
        ext_d = 1'b1;
      end else if (code == SC_BRK) begin
        brk_d = 1'b1;
      end else if (ext_q || brk_q) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else if (hex[4]) begin
        if (!err_q) begin
          if (n_q == 4'd8) begin
            err_d = 1'b1;
          end else begin
            numb_d = {numb_q[27:0], hex[3:0]};
            n_d    = n_q + 4'd1;
          end
        end
      end else if (code == SC_BKSP) begin
        if (!err_q && n_q != 4'd0) begin
          numb_d = numb_q >> 4;
          n_d    = n_q - 4'd1;
        end
      end else if (code == SC_ESC) begin
        numb_d = '0;
        n_d    = '0;
        err_d  = 1'b0;
      end
    end
    if (rx_err) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      numb_q <= '0;
      n_q    <= '0;
      err_q  <= 1'b0;
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
    end else begin
      numb_q <= numb_d;
      n_q    <= n_d;
      err_q  <= err_d;
      ext_q  <= ext_d;
      brk_q  <= brk_d;
    end
  end

  // With nothing entered a single "0" stays visible.
  always_comb begin
    n_eff = (n_q == 4'd0) ? 4'd1 : n_q;
    for (int i = 0; i < 8; i++) MASK[i] = (4'(i) >= n_eff);
  end

  assign NUMB  = numb_q;
  assign ERROR = err_q;

endmodule

// File: tb/tb_ps2_hex_entry.sv
// Directed bench for ps2_hex_entry: bit-banged PS/2 frames with hand-computed
// expected NUMB/MASK/ERROR/code values.
module tb_ps2_hex_entry;

  localparam int unsigned Tmo = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [31:0] NUMB;
  logic        ERROR;
  logic [7:0]  MASK;
  logic [7:0]  code;
  logic        code_valid;

  int total = 0;
  int bad = 0;
  int cv_count = 0;

  ps2_hex_entry #(
    .TIMEOUT_CYCLES(Tmo),
    .SYNC_STAGES   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .NUMB      (NUMB),
    .ERROR     (ERROR),
    .MASK      (MASK),
    .code      (code),
    .code_valid(code_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (code_valid) cv_count++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (10) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (20) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic good_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(good_par ? ~^b : ^b);
    send_bit(1'b1);
    repeat (30) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic key(input logic [7:0] b);
    send_frame(b, 1'b1);
  endtask

  int cv0;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_numb", NUMB, 32'h0);
    check("rst_mask", MASK, 8'hFE);
    check("rst_err", ERROR, 1'b0);
    check("rst_code", code, 8'h00);
    check("rst_cv", code_valid, 1'b0);
    rst = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    check("idle_no_cv", cv_count, 0);

    // First key
    key(8'h16);
    check("k1_cv", cv_count, 1);
    check("k1_code", code, 8'h16);
    check("k1_numb", NUMB, 32'h1);
    check("k1_mask", MASK, 8'hFE);

    // 1,2,3 then backspace
    key(8'h76);
    key(8'h16); key(8'h1E); key(8'h26);
    check("k123_numb", NUMB, 32'h123);
    check("k123_mask", MASK, 8'hF8);
    key(8'h66);
    check("bksp_numb", NUMB, 32'h12);
    check("bksp_mask", MASK, 8'hFC);

    // Bad parity frame
    cv0 = cv_count;
    send_frame(8'h1E, 1'b0);
    check("par_err", ERROR, 1'b1);
    check("par_no_cv", cv_count, cv0);
    check("par_numb", NUMB, 32'h12);
    key(8'h1E);
    check("err_ignore_numb", NUMB, 32'h12);
    check("err_ignore_code", code, 8'h1E);
    key(8'h76);
    check("esc_err", ERROR, 1'b0);
    check("esc_numb", NUMB, 32'h0);
    check("esc_mask", MASK, 8'hFE);

    // Break and extended prefixes
    key(8'hF0); key(8'h16);
    check("brk_numb", NUMB, 32'h0);
    check("brk_mask", MASK, 8'hFE);
    key(8'hE0); key(8'h70);
    check("ext_numb", NUMB, 32'h0);
    key(8'h16);
    check("after_pfx_numb", NUMB, 32'h1);

    // Eight digits then overflow
    key(8'h76);
    key(8'h16); key(8'h1E); key(8'h26); key(8'h25);
    key(8'h2E); key(8'h36); key(8'h3D); key(8'h3E);
    check("full_numb", NUMB, 32'h12345678);
    check("full_mask", MASK, 8'h00);
    check("full_err", ERROR, 1'b0);
    key(8'h46);
    check("ovf_err", ERROR, 1'b1);
    check("ovf_numb", NUMB, 32'h12345678);

    // Partial frame timeout
    key(8'h76);
    check("pre_tmo_err", ERROR, 1'b0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    repeat (Tmo + 50) @(posedge clk);
    @(negedge clk);
    check("tmo_err", ERROR, 1'b1);
    key(8'h76);
    cv0 = cv_count;
    key(8'h45);
    check("tmo_rec_cv", cv_count, cv0 + 1);
    check("tmo_rec_numb", NUMB, 32'h0);
    check("tmo_rec_mask", MASK, 8'hFE);
    key(8'h16);
    check("tmo_rec_n2_numb", NUMB, 32'h01);
    check("tmo_rec_n2_mask", MASK, 8'hFC);

    // Reset mid-frame
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    rst = 1'b1;
    repeat (150) @(posedge clk);
    @(negedge clk);
    check("midrst_numb", NUMB, 32'h0);
    check("midrst_err", ERROR, 1'b0);
    check("midrst_mask", MASK, 8'hFE);
    key(8'h2B);
    check("midrst_rec_numb", NUMB, 32'hF);
    check("midrst_rec_code", code, 8'h2B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
